// File: rtl/iob_nco_mc.sv
// Multi-channel fractional NCO: N_CH square-wave generators with INT_W.FRAC_W periods,
// programmable duty/phase, boundary-synchronous register updates and a common sync.

module iob_nco_mc_ch #(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 16
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              soft_reset_i,
  input  logic              i_en,
  input  logic              i_sync,
  input  logic [3:0]        i_wr,
  input  logic [INT_W-1:0]  i_wint,
  input  logic [FRAC_W-1:0] i_wfrac,
  output logic              o_clk,
  output logic              o_tick
);
  localparam int LW = INT_W + 1;

  logic [INT_W-1:0]  r_int_sh, r_duty_sh, r_ph_sh;
  logic [INT_W-1:0]  r_int_act, r_duty_act, r_ph_act;
  logic [FRAC_W-1:0] r_frac_sh, r_facc;
  logic [LW-1:0]     r_cnt, r_len;
  logic              r_run;

  logic [LW-1:0]     w_eff_act, w_eff_sh, w_cnt_n, w_len_n, w_duty_eff;
  logic [FRAC_W-1:0] w_facc_n, w_fsum;
  logic [INT_W-1:0]  w_duty_n;
  logic              w_carry, w_run_n, w_load, w_bnd;

  assign w_eff_act = (r_int_act < INT_W'(2)) ? LW'(2) : {1'b0, r_int_act};
  assign w_eff_sh  = (r_int_sh  < INT_W'(2)) ? LW'(2) : {1'b0, r_int_sh};
  assign w_bnd     = r_run && (r_cnt == r_len - LW'(1));
  assign {w_carry, w_fsum} = {1'b0, r_facc} + {1'b0, r_frac_sh};

  // Outputs are registered from the next-state count, so duty uses the next len/duty too.
  always_comb begin
    w_cnt_n  = r_cnt + LW'(1);
    w_facc_n = r_facc;
    w_len_n  = r_len;
    w_duty_n = r_duty_act;
    w_run_n  = r_run;
    w_load   = 1'b0;
    if (!i_en) begin
      w_cnt_n  = '0;
      w_facc_n = '0;
      w_run_n  = 1'b0;
      w_load   = 1'b1;
    end else if (!r_run || i_sync) begin
      w_cnt_n  = ({1'b0, r_ph_act} < w_eff_act) ? {1'b0, r_ph_act} : '0;
      w_facc_n = '0;
      w_len_n  = w_eff_act;
      w_run_n  = 1'b1;
    end else if (w_bnd) begin
      w_cnt_n  = '0;
      w_facc_n = w_fsum;
      w_len_n  = w_eff_sh + LW'(w_carry);
      w_duty_n = r_duty_sh;
      w_load   = 1'b1;
    end
    w_duty_eff = (w_duty_n == '0) ? (w_len_n >> 1) : {1'b0, w_duty_n};
  end

  // Shadow writes land even with cke_i low: an acknowledged write is never dropped.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_int_sh <= '0; r_frac_sh <= '0; r_duty_sh <= '0; r_ph_sh <= '0;
      r_int_act <= '0; r_duty_act <= '0; r_ph_act <= '0;
      r_cnt <= '0; r_len <= '0; r_facc <= '0; r_run <= 1'b0;
      o_clk <= 1'b0; o_tick <= 1'b0;
    end else if (soft_reset_i) begin
      r_int_sh <= '0; r_frac_sh <= '0; r_duty_sh <= '0; r_ph_sh <= '0;
      r_int_act <= '0; r_duty_act <= '0; r_ph_act <= '0;
      r_cnt <= '0; r_len <= '0; r_facc <= '0; r_run <= 1'b0;
      o_clk <= 1'b0; o_tick <= 1'b0;
    end else begin
      if (i_wr[0]) r_int_sh  <= i_wint;
      if (i_wr[1]) r_frac_sh <= i_wfrac;
      if (i_wr[2]) r_duty_sh <= i_wint;
      if (i_wr[3]) r_ph_sh   <= i_wint;
      if (cke_i) begin
        r_cnt  <= w_cnt_n;
        r_facc <= w_facc_n;
        r_len  <= w_len_n;
        r_run  <= w_run_n;
        if (w_load) begin
          r_int_act  <= r_int_sh;
          r_duty_act <= r_duty_sh;
          r_ph_act   <= r_ph_sh;
        end
        o_clk  <= i_en && (w_cnt_n < w_duty_eff);
        o_tick <= i_en && (w_cnt_n == '0);
      end
    end
  end
endmodule

module iob_nco_mc #(
  parameter int N_CH   = 4,
  parameter int INT_W  = 16,
  parameter int FRAC_W = 16,
  parameter int DATA_W = 32,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_n_i,
  input  logic              soft_reset_i,
  input  logic [N_CH-1:0]   en_i,
  input  logic              sync_i,
  input  logic              cfg_valid_i,
  input  logic [CH_W+1:0]   cfg_addr_i,
  input  logic [DATA_W-1:0] cfg_wdata_i,
  output logic              cfg_ready_o,
  output logic [N_CH-1:0]   clk_out_o,
  output logic [N_CH-1:0]   tick_o
);
  logic [CH_W-1:0] w_ch;
  logic [1:0]      w_reg;
  logic            w_acc;
  logic            w_unused;

  assign cfg_ready_o = !soft_reset_i;
  assign w_acc       = cfg_valid_i && cfg_ready_o;
  assign w_ch        = cfg_addr_i[CH_W+1:2];
  assign w_reg       = cfg_addr_i[1:0];
  assign w_unused    = ^cfg_wdata_i;

  // Channel indices >= N_CH match no instance, so those writes are acked and dropped.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [3:0] w_wr;
    assign w_wr = (w_acc && (w_ch == CH_W'(g))) ? (4'b0001 << w_reg) : 4'b0000;
    iob_nco_mc_ch #(.INT_W(INT_W), .FRAC_W(FRAC_W)) u_ch (
      .clk_i        (clk_i),
      .arst_n_i     (arst_n_i),
      .cke_i        (cke_i),
      .soft_reset_i (soft_reset_i),
      .i_en         (en_i[g]),
      .i_sync       (sync_i),
      .i_wr         (w_wr),
      .i_wint       (cfg_wdata_i[INT_W-1:0]),
      .i_wfrac      (cfg_wdata_i[FRAC_W-1:0]),
      .o_clk        (clk_out_o[g]),
      .o_tick       (tick_o[g])
    );
  end
endmodule
